// File: rtl/arm_mc_controller.sv
// arm_mc_controller: multicycle sequencer for the ARMv4-subset datapath.
// Define ARM_MC_CMP_TST_EN to decode CMP/TST; otherwise they execute as NOPs.
module arm_mc_controller #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  input  logic         MemReady,
  output logic         PCWrite,
  output logic         AdrSrc,
  output logic         MemWrite,
  output logic         IRWrite,
  output logic         RegWrite,
  output logic [1:0]   ResultSrc,
  output logic         ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ALUControl,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   RegSrc,
  output logic         Fault,
  output logic [3:0]   State
);
  localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(WAIT_LIMIT);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_HALT     = 4'd10
  } state_e;

  state_e        state_q, state_d, cur;
  logic [3:0]    flags_q, flags_d;
  logic          condex_q, condex_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fault_q, fault_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = Instr[31:28];
  assign op        = Instr[27:26];
  assign funct     = Instr[25:20];
  assign rd        = Instr[15:12];
  assign unused_rn = ^Instr[19:16];

  assign ImmSrc = op;
  assign RegSrc = {(op == 2'b01) && !funct[0], op == 2'b10};
  assign Fault  = fault_q;
  assign State  = state_q;

  logic n_f, z_f, c_f, v_f, cond_pass;
  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0:    cond_pass = z_f;
      4'h1:    cond_pass = !z_f;
      4'h2:    cond_pass = c_f;
      4'h3:    cond_pass = !c_f;
      4'h4:    cond_pass = n_f;
      4'h5:    cond_pass = !n_f;
      4'h6:    cond_pass = v_f;
      4'h7:    cond_pass = !v_f;
      4'h8:    cond_pass = c_f && !z_f;
      4'h9:    cond_pass = !c_f || z_f;
      4'ha:    cond_pass = n_f == v_f;
      4'hb:    cond_pass = n_f != v_f;
      4'hc:    cond_pass = !z_f && (n_f == v_f);
      4'hd:    cond_pass = z_f || (n_f != v_f);
      4'he:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // arith: op produces C/V; known=0 is the NOP path
  logic [1:0] alu_dp;
  logic       nowrite, known, arith;

  always_comb begin
    alu_dp  = 2'b00;
    nowrite = 1'b1;
    known   = 1'b0;
    arith   = 1'b0;
    case (funct[4:1])
      4'b0100: begin nowrite = 1'b0; known = 1'b1; arith = 1'b1; end
      4'b0010: begin alu_dp = 2'b01; nowrite = 1'b0;
                     known = 1'b1; arith = 1'b1; end
      4'b0000: begin alu_dp = 2'b10; nowrite = 1'b0; known = 1'b1; end
      4'b1100: begin alu_dp = 2'b11; nowrite = 1'b0; known = 1'b1; end
`ifdef ARM_MC_CMP_TST_EN
      4'b1010: begin alu_dp = 2'b01; known = 1'b1; arith = 1'b1; end
      4'b1000: begin alu_dp = 2'b10; known = 1'b1; end
`endif
      default: ;
    endcase
  end

  logic mem_st, timeout;

  always_comb begin
    cur        = reset ? S_FETCH : state_q;
    state_d    = cur;
    flags_d    = flags_q;
    condex_d   = condex_q;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    mem_st     = 1'b0;
    case (cur)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        mem_st    = 1'b1;
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        condex_d = cond_pass;
        case (op)
          2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        mem_st = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = condex_q;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = condex_q;
        mem_st   = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (cur == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl = alu_dp;
        if (funct[0] && condex_q && known) begin
          flags_d[3:2] = ALUFlags[3:2];
          if (arith) flags_d[1:0] = ALUFlags[1:0];
        end
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = condex_q && !nowrite;
        PCWrite  = condex_q && (rd == 4'hf) && !nowrite;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = condex_q;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    timeout = mem_st && !MemReady && (WAIT_LIMIT != 0) && (cnt_q == LIM);
    if (timeout) state_d = S_HALT;
    cnt_d = '0;
    if (mem_st && !MemReady && state_d == cur)
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    fault_d = fault_q || (state_d == S_HALT);
    if (reset) begin
      PCWrite = 1'b0;
      IRWrite = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      flags_q  <= '0;
      condex_q <= 1'b0;
      cnt_q    <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
      cnt_q    <= cnt_d;
      fault_q  <= fault_d;
    end
  end
endmodule

// File: tb/tb_arm_mc_controller.sv
// tb_arm_mc_controller: cycle-vector table with scoreboard queue,
// plus a hand-driven fetch-timeout sequence.
module tb_arm_mc_controller;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:12] Instr = '0;
  logic [3:0]   ALUFlags = '0;
  logic         MemReady = 1'b1;
  logic         PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0]   ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic         ALUSrcA, Fault;
  logic [3:0]   State;

  arm_mc_controller #(.WAIT_LIMIT(15)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .Fault(Fault), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [19:0] ins;
    logic [3:0]  flg;
    logic        mr;
    logic [3:0]  st;
    logic [3:0]  en;   // {PCWrite, IRWrite, RegWrite, MemWrite}
    logic [1:0]  alu;
    logic        flt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [19:0] ADD   = 20'hE2801;
  localparam logic [19:0] ADDS  = 20'hE2900;
  localparam logic [19:0] LDR   = 20'hE5910;
  localparam logic [19:0] SUBS  = 20'hE0522;
  localparam logic [19:0] BEQ   = 20'h0A000;
  localparam logic [19:0] BNE   = 20'h1A000;
  localparam logic [19:0] STRNE = 20'h15810;
  localparam logic [19:0] CMP   = 20'hE3510;
  localparam logic [19:0] OP11  = 20'hEC000;
  localparam logic [3:0] F0 = 4'h0, ZC = 4'h6;
  localparam logic [3:0] E0 = 4'b0000, EF = 4'b1100;
  localparam logic [3:0] ERW = 4'b0010, EPC = 4'b1000;
  localparam logic [1:0] AADD = 2'b00, ASUB = 2'b01;
  localparam logic H = 1'b1, L = 1'b0;
`ifdef ARM_MC_CMP_TST_EN
  localparam logic [1:0] CMP_ALU = 2'b01;
  localparam logic [3:0] BEQ_EN = 4'b1000;
`else
  localparam logic [1:0] CMP_ALU = 2'b00;
  localparam logic [3:0] BEQ_EN = 4'b0000;
`endif

  function automatic vec_t mk(logic r, logic [19:0] i, logic [3:0] f,
                              logic m, logic [3:0] s, logic [3:0] e,
                              logic [1:0] a, logic fl);
    vec_t v;
    v.rst = r; v.ins = i; v.flg = f; v.mr = m;
    v.st = s; v.en = e; v.alu = a; v.flt = fl;
    return v;
  endfunction

  // {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}: required value and care mask
  function automatic logic [11:0] mux_exp(logic [3:0] s);
    case (s)
      4'd0:    return {6'b011010, 6'b111111};
      4'd1:    return {6'b011000, 6'b011100};
      4'd2:    return {6'b000100, 6'b011100};
      4'd3:    return {6'b100000, 6'b100011};
      4'd4:    return {6'b000001, 6'b000011};
      4'd5:    return {6'b100000, 6'b100000};
      4'd6:    return {6'b000000, 6'b011100};
      4'd7:    return {6'b000100, 6'b011100};
      4'd8:    return {6'b000000, 6'b000011};
      4'd9:    return {6'b000110, 6'b011111};
      default: return 12'h000;
    endcase
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s v%0d: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset    = v.rst;
    Instr    = v.ins;
    ALUFlags = v.flg;
    MemReady = v.mr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t e;
    logic [3:0]  key;
    logic [11:0] mx;
    logic [5:0]  act;
    int cyc;
    logic irw_seen;

    repeat (3) vecs.push_back(mk(H, ADD, F0, H, 4'd0, E0, AADD, L));
    // ADD R1,R0,#5
    vecs.push_back(mk(L, ADD, F0, H, 4'd0, EF, AADD, L));
    vecs.push_back(mk(L, ADD, F0, H, 4'd1, E0, AADD, L));
    vecs.push_back(mk(L, ADD, F0, H, 4'd7, E0, AADD, L));
    vecs.push_back(mk(L, ADD, F0, H, 4'd8, ERW, AADD, L));
    // LDR with two wait cycles in MEMREAD
    vecs.push_back(mk(L, LDR, F0, H, 4'd0, EF, AADD, L));
    vecs.push_back(mk(L, LDR, F0, H, 4'd1, E0, AADD, L));
    vecs.push_back(mk(L, LDR, F0, H, 4'd2, E0, AADD, L));
    vecs.push_back(mk(L, LDR, F0, L, 4'd3, E0, AADD, L));
    vecs.push_back(mk(L, LDR, F0, L, 4'd3, E0, AADD, L));
    vecs.push_back(mk(L, LDR, F0, H, 4'd3, E0, AADD, L));
    vecs.push_back(mk(L, LDR, F0, H, 4'd4, ERW, AADD, L));
    // SUBS R2,R2,R2 -> Z=1 C=1, then BEQ taken, BNE not taken
    vecs.push_back(mk(L, SUBS, F0, H, 4'd0, EF, AADD, L));
    vecs.push_back(mk(L, SUBS, F0, H, 4'd1, E0, AADD, L));
    vecs.push_back(mk(L, SUBS, ZC, H, 4'd6, E0, ASUB, L));
    vecs.push_back(mk(L, SUBS, F0, H, 4'd8, ERW, AADD, L));
    vecs.push_back(mk(L, BEQ, F0, H, 4'd0, EF, AADD, L));
    vecs.push_back(mk(L, BEQ, F0, H, 4'd1, E0, AADD, L));
    vecs.push_back(mk(L, BEQ, F0, H, 4'd9, EPC, AADD, L));
    vecs.push_back(mk(L, BNE, F0, H, 4'd0, EF, AADD, L));
    vecs.push_back(mk(L, BNE, F0, H, 4'd1, E0, AADD, L));
    vecs.push_back(mk(L, BNE, F0, H, 4'd9, E0, AADD, L));
    // STRNE while Z=1 -> no MemWrite
    vecs.push_back(mk(L, STRNE, F0, H, 4'd0, EF, AADD, L));
    vecs.push_back(mk(L, STRNE, F0, H, 4'd1, E0, AADD, L));
    vecs.push_back(mk(L, STRNE, F0, H, 4'd2, E0, AADD, L));
    vecs.push_back(mk(L, STRNE, F0, H, 4'd5, E0, AADD, L));
    // ADDS clears flags, CMP R1,#5 with ALU Z=1 C=1, then BEQ
    vecs.push_back(mk(L, ADDS, F0, H, 4'd0, EF, AADD, L));
    vecs.push_back(mk(L, ADDS, F0, H, 4'd1, E0, AADD, L));
    vecs.push_back(mk(L, ADDS, F0, H, 4'd7, E0, AADD, L));
    vecs.push_back(mk(L, ADDS, F0, H, 4'd8, ERW, AADD, L));
    vecs.push_back(mk(L, CMP, F0, H, 4'd0, EF, AADD, L));
    vecs.push_back(mk(L, CMP, F0, H, 4'd1, E0, AADD, L));
    vecs.push_back(mk(L, CMP, ZC, H, 4'd7, E0, CMP_ALU, L));
    vecs.push_back(mk(L, CMP, F0, H, 4'd8, E0, AADD, L));
    vecs.push_back(mk(L, BEQ, F0, H, 4'd0, EF, AADD, L));
    vecs.push_back(mk(L, BEQ, F0, H, 4'd1, E0, AADD, L));
    vecs.push_back(mk(L, BEQ, F0, H, 4'd9, BEQ_EN, AADD, L));
    // Op==11 halts; reset recovers
    vecs.push_back(mk(L, OP11, F0, H, 4'd0, EF, AADD, L));
    vecs.push_back(mk(L, OP11, F0, H, 4'd1, E0, AADD, L));
    vecs.push_back(mk(L, OP11, F0, H, 4'd10, E0, AADD, H));
    vecs.push_back(mk(L, OP11, F0, H, 4'd10, E0, AADD, H));
    vecs.push_back(mk(H, OP11, F0, H, 4'd10, E0, AADD, H));
    // reset in ALUWB discards the register write
    vecs.push_back(mk(L, ADD, F0, H, 4'd0, EF, AADD, L));
    vecs.push_back(mk(L, ADD, F0, H, 4'd1, E0, AADD, L));
    vecs.push_back(mk(L, ADD, F0, H, 4'd7, E0, AADD, L));
    vecs.push_back(mk(H, ADD, F0, H, 4'd8, E0, AADD, L));
    // 10 fetch waits, then 15 read waits: at the limit but no fault
    repeat (10) vecs.push_back(mk(L, LDR, F0, L, 4'd0, E0, AADD, L));
    vecs.push_back(mk(L, LDR, F0, H, 4'd0, EF, AADD, L));
    vecs.push_back(mk(L, LDR, F0, H, 4'd1, E0, AADD, L));
    vecs.push_back(mk(L, LDR, F0, H, 4'd2, E0, AADD, L));
    repeat (15) vecs.push_back(mk(L, LDR, F0, L, 4'd3, E0, AADD, L));
    vecs.push_back(mk(L, LDR, F0, H, 4'd3, E0, AADD, L));
    vecs.push_back(mk(L, LDR, F0, H, 4'd4, ERW, AADD, L));
    // 16th stalled fetch cycle times out
    repeat (16) vecs.push_back(mk(L, ADD, F0, L, 4'd0, E0, AADD, L));
    vecs.push_back(mk(L, ADD, F0, L, 4'd10, E0, AADD, H));
    vecs.push_back(mk(L, ADD, F0, H, 4'd10, E0, AADD, H));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      sb.push_back(vecs[i]);
      @(negedge clk);
      e = sb.pop_front();
      key = e.rst ? 4'd0 : e.st;
      chk("state", i, {4'h0, State}, {4'h0, e.st});
      chk("enables", i, {4'h0, PCWrite, IRWrite, RegWrite, MemWrite},
          {4'h0, e.en});
      chk("fault", i, {7'h0, Fault}, {7'h0, e.flt});
      mx  = mux_exp(key);
      act = {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc};
      if (mx[5:0] != 6'h0)
        chk("mux", i, {2'b00, act & mx[5:0]}, {2'b00, mx[11:6] & mx[5:0]});
      if (key inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd9})
        chk("aluctl", i, {6'h0, ALUControl}, {6'h0, e.alu});
      chk("immsrc", i, {6'h0, ImmSrc}, {6'h0, e.ins[15:14]});
      chk("regsrc", i, {6'h0, RegSrc},
          {6'h0, (e.ins[15:14] == 2'b01) && !e.ins[8],
           e.ins[15:14] == 2'b10});
    end

    // fetch stall from a clean reset: count cycles until Fault
    @(posedge clk);
    #1;
    reset = 1'b1;
    MemReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_fault", 0, {7'h0, Fault}, 8'h00);
    cyc = 0;
    irw_seen = 1'b0;
    while (!Fault && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (IRWrite) irw_seen = 1'b1;
    end
    chk("timeout_cyc", 0, 8'(cyc), 8'd16);
    chk("timeout_st", 0, {4'h0, State}, 8'd10);
    chk("timeout_irw", 0, {7'h0, irw_seen}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
